// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding and constants for the SRAM memory controller.
package sram_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;
   localparam int SRAM_AW = 18;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/wait_counter.sv
// wait_counter: per-phase wait-state counter with a last-cycle flag.
module wait_counter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       en,
   output logic [3:0] count,
   output logic       last
);
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (clear) count <= '0;
      else if (en) count <= count + 4'd1;
   assign last = count == 4'(WAIT_CYCLES - 1);
endmodule

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: splits 32-bit MEM-stage accesses into two wait-stated 16-bit SRAM phases.
module sram_mem_controller
   import sram_ctrl_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_we_n
);
   state_t      state, state_nxt;
   logic        op_wr, req, active, last;
   logic [31:0] wdata;
   logic [16:0] word, word_in;
   logic [3:0]  cnt;

   assign req     = rd_en | wr_en;
   assign active  = state == LOW || state == HIGH;
   assign word_in = 17'((address - BASE_ADDR) >> 2);

   wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (state_nxt != state),
      .en    (active),
      .count (cnt),
      .last  (last)
   );

   always_comb begin
      state_nxt = state == IDLE ? (req ? LOW : IDLE) :
                  state == DONE ? IDLE :
                  last ? (state == LOW ? HIGH : DONE) : state;
      ready       = state == IDLE ? ~req : state == DONE;
      sram_addr   = {word, state == HIGH};
      sram_dq_out = state == HIGH ? wdata[31:16] : wdata[15:0];
      sram_dq_oe  = active & op_wr;
      // strobe rises on the final phase cycle so the address is held through the write edge
      sram_we_n   = ~(active & op_wr & (cnt != 4'(WAIT_CYCLES - 1)));
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         op_wr     <= 1'b0;
         wdata     <= '0;
         word      <= '0;
         read_data <= '0;
      end else begin
         if (state == IDLE && req) begin
            op_wr <= wr_en;
            wdata <= write_data;
            word  <= word_in;
         end
         if (active && !op_wr && last) begin
            if (state == HIGH) read_data[31:16] <= sram_dq_in;
            else read_data[15:0] <= sram_dq_in;
         end
      end
endmodule
